// File: rtl/mix_columns_serial.sv
// mix_columns_serial: column-serial AES MixColumns stage.
// One 32-bit column is mixed per clock through a single shared column
// multiplier. Blocks enter and leave over valid/ready handshakes, and a
// per-block bypass flag passes the state through unmixed (final round).
// Optional build macro: MIX_COLUMNS_INVERSE_EN adds InvMixColumns, selected
// per block by in_inverse. Without it, in_inverse is ignored.
module mix_columns_serial (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] COL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   fsm;
    logic [1:0]   col;
    logic [127:0] state_q;
    logic [127:0] next_state;
    logic [31:0]  cur_col;
    logic [31:0]  mixed_col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIX_COLUMNS_INVERSE_EN
    logic inverse_q;

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    endfunction
`else
    logic unused_inverse;
    assign unused_inverse = in_inverse;
`endif

    // Status outputs decode registered state only.
    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == COL);
    assign out_data  = state_q;

    // Select the column being processed and run it through the multiplier.
    always_comb begin
        cur_col = '0;
        case (col)
            2'd0:    cur_col = state_q[127:96];
            2'd1:    cur_col = state_q[95:64];
            2'd2:    cur_col = state_q[63:32];
            default: cur_col = state_q[31:0];
        endcase
`ifdef MIX_COLUMNS_INVERSE_EN
        mixed_col = inverse_q ? mix_inv(cur_col) : mix_fwd(cur_col);
`else
        mixed_col = mix_fwd(cur_col);
`endif
    end

    // Write the mixed column back; the other three columns hold.
    always_comb begin
        next_state = state_q;
        case (col)
            2'd0:    next_state[127:96] = mixed_col;
            2'd1:    next_state[95:64]  = mixed_col;
            2'd2:    next_state[63:32]  = mixed_col;
            default: next_state[31:0]   = mixed_col;
        endcase
    end

    // Control FSM and state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm     <= IDLE;
            col     <= '0;
            state_q <= '0;
`ifdef MIX_COLUMNS_INVERSE_EN
            inverse_q <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_data;
`ifdef MIX_COLUMNS_INVERSE_EN
                        inverse_q <= in_inverse;
`endif
                        col <= '0;
                        fsm <= in_bypass ? DONE : COL;
                    end
                end
                COL: begin
                    state_q <= next_state;
                    col     <= col + 2'd1;
                    if (col == 2'd3) fsm <= DONE;
                end
                DONE: begin
                    if (out_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Testbench for mix_columns_serial: directed FIPS-197 vectors plus random
// blocks, checked against a matrix-level GF(2^8) reference model.
module tb_mix_columns_serial;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         in_inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] BYP_IN   = 128'h3925841d02dc09fbdc118597196a0b32;

    mix_columns_serial dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_bypass  (in_bypass),
        .in_inverse (in_inverse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // GF(2^8) multiply by shift-and-add followed by reduction mod 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Reference block transform: circulant matrix product per column.
    function automatic logic [127:0] ref_block(input logic [127:0] din, input logic byp, input logic inv);
        logic [7:0]   base [4];
        logic [7:0]   a [4];
        logic [7:0]   r;
        logic [127:0] res;
        logic         use_inv;
`ifdef MIX_COLUMNS_INVERSE_EN
        use_inv = inv;
`else
        use_inv = 1'b0;
        if (inv) use_inv = 1'b0;
`endif
        if (byp) return din;
        base[0] = use_inv ? 8'h0e : 8'h02;
        base[1] = use_inv ? 8'h0b : 8'h03;
        base[2] = use_inv ? 8'h0d : 8'h01;
        base[3] = use_inv ? 8'h09 : 8'h01;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = din[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                r = '0;
                for (int k = 0; k < 4; k++) r = r ^ gmul(base[(k - row + 4) % 4], a[k]);
                res[127 - 32*c - 8*row -: 8] = r;
            end
        end
        return res;
    endfunction

    // Model of the block in flight; outputs are checked every cycle.
    logic         m_pend = 1'b0;
    logic         m_byp  = 1'b0;
    logic [127:0] m_exp  = '0;
    int           m_acc  = 0;

    always @(negedge clock) begin
        int   el;
        logic ev, eb;
        ev = 1'b0;
        eb = 1'b0;
        el = cyc - m_acc;
        if (m_pend) begin
            ev = (el >= (m_byp ? 0 : 4));
            eb = !m_byp && (el < 4);
        end
        if (!reset) begin
            check("in_ready", {127'd0, in_ready}, {127'd0, !m_pend});
            check("out_valid", {127'd0, out_valid}, {127'd0, ev});
            check("busy", {127'd0, busy}, {127'd0, eb});
            if (ev) check("out_data", out_data, m_exp);
        end
        if (reset) begin
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (ev && out_ready) m_pend = 1'b0;
        end else if (in_valid) begin
            m_pend = 1'b1;
            m_byp  = in_bypass;
            m_exp  = ref_block(in_data, in_bypass, in_inverse);
            m_acc  = cyc + 1;
        end
    end

    // Present a block and hold it until accepted; ends one step after the edge.
    task automatic accept(input logic [127:0] d, input logic byp, input logic inv,
                          input logic keep, output int at);
        logic r;
        in_data    = d;
        in_bypass  = byp;
        in_inverse = inv;
        in_valid   = 1'b1;
        at = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            r = in_ready;
            @(posedge clock);
            #1;
            if (r) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("accept_timeout", 128'd0, 128'd1);
        if (!keep) in_valid = 1'b0;
    endtask

    // Count falling edges until out_valid shows up; returns at that edge.
    task automatic wait_out(output int k, output logic busy_seen);
        k = 0;
        busy_seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            k++;
            if (busy) busy_seen = 1'b1;
            if (out_valid) return;
        end
        check("out_timeout", 128'd0, 128'd1);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           k;
        int           t [3];
        int           at;
        logic         bs;
        logic         hs;
        logic [127:0] hold;
        logic [127:0] d;

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_bypass = 1'b0;
        in_inverse = 1'b0;
        out_ready = 1'b0;

        check("model_fwd", ref_block(FIPS_IN, 1'b0, 1'b0), FIPS_OUT);
        check("model_byp", ref_block(BYP_IN, 1'b1, 1'b0), BYP_IN);
`ifdef MIX_COLUMNS_INVERSE_EN
        check("model_inv", ref_block(FIPS_OUT, 1'b0, 1'b1), FIPS_IN);
`endif

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        step();

        // FIPS-197 forward vector and latency.
        out_ready = 1'b1;
        accept(FIPS_IN, 1'b0, 1'b0, 1'b0, at);
        wait_out(k, bs);
        check("fwd_latency", 128'(k), 128'd5);
        check("fwd_data", out_data, FIPS_OUT);
        step();

        // Bypass: one-cycle latency, data untouched, busy never high.
        accept(BYP_IN, 1'b1, 1'b0, 1'b0, at);
        wait_out(k, bs);
        check("byp_latency", 128'(k), 128'd1);
        check("byp_data", out_data, BYP_IN);
        check("byp_busy", {127'd0, bs}, 128'd0);
        step();

`ifdef MIX_COLUMNS_INVERSE_EN
        accept(FIPS_OUT, 1'b0, 1'b1, 1'b0, at);
        wait_out(k, bs);
        check("inv_latency", 128'(k), 128'd5);
        check("inv_data", out_data, FIPS_IN);
        step();
`endif

        // Backpressure with a pending input.
        out_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        accept(d, 1'b0, 1'b0, 1'b0, at);
        wait_out(k, bs);
        hold = out_data;
        check("bp_data", hold, ref_block(d, 1'b0, 1'b0));
        step();
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_hold", out_data, hold);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", {127'd0, in_ready}, 128'd0);
        step();
        @(negedge clock);
        check("bp_after_ready", {127'd0, in_ready}, 128'd1);
        step();
        in_valid = 1'b0;
        wait_out(k, bs);
        step();

        // Reset while column 2 is being processed.
        accept({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0, at);
        step();
        step();
        check("mid_busy", {127'd0, busy}, 128'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("mid_in_ready", {127'd0, in_ready}, 128'd1);
        check("mid_out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_out_data", out_data, 128'd0);
        step();
        d = {$urandom, $urandom, $urandom, $urandom};
        accept(d, 1'b0, 1'b0, 1'b0, at);
        wait_out(k, bs);
        check("mid_next_data", out_data, ref_block(d, 1'b0, 1'b0));
        step();

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            accept({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, t[i]);
        in_valid = 1'b0;
        check("b2b_gap01", 128'(t[1] - t[0]), 128'd6);
        check("b2b_gap12", 128'(t[2] - t[1]), 128'd6);
        wait_out(k, bs);
        step();

        // Random blocks with random bypass/inverse and output stalls.
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            accept({$urandom, $urandom, $urandom, $urandom},
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0, at);
            hs = 1'b0;
            for (int n = 0; n < 200 && !hs; n++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clock);
                hs = out_valid && out_ready;
                step();
            end
            if (!hs) check("rand_timeout", 128'd0, 128'd1);
        end

        out_ready = 1'b1;
        repeat (8) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
